banked_ram: RTL

Parametrised multi-port, bank-interleaved synchronous RAM; the next-generation replacement for the four-index combinational entry store in the multicycle datapath. NUM_PORTS independent requesters issue read/write requests through a valid/ready handshake. Each bank has a round-robin arbiter that serialises bank conflicts. Read data returns with fixed latency and a per-port response strobe.

---
 rtl/banked_ram.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/banked_ram.sv
// banked_ram: multi-port, low-order interleaved banked RAM with per-bank round-robin arbiters.
// Define BANKED_RAM_OUTREG_EN for an extra output register stage (2-cycle read latency).
module banked_ram #(
  parameter int    ENTRY_WIDTH = 8,
  parameter int    SIZE        = 1024,
  parameter int    NUM_PORTS   = 4,
  parameter int    NUM_BANKS   = 4,
  parameter string FILE_NAME   = ""
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_wr,
  input  logic [NUM_PORTS*32-1:0]          index,
  input  logic [NUM_PORTS*ENTRY_WIDTH-1:0] entry,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [NUM_PORTS*ENTRY_WIDTH-1:0] entry_out
);

  localparam int AW = $clog2(SIZE);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [ENTRY_WIDTH-1:0] mem [SIZE];

  logic [BW-1:0]          bank   [NUM_PORTS];
  logic [AW-1:0]          addr   [NUM_PORTS];
  logic [NUM_PORTS-1:0]   in_rng;
  logic [NUM_PORTS-1:0]   gnt;
  logic                   hit;
  logic [PW-1:0]          sel;

  logic [PW-1:0]          rr_q   [NUM_BANKS];
  logic [PW-1:0]          rr_d   [NUM_BANKS];
  logic [NUM_PORTS-1:0]   rsp_q;
  logic [NUM_PORTS-1:0]   rsp_d;
  logic [ENTRY_WIDTH-1:0] dat_q  [NUM_PORTS];
  logic [ENTRY_WIDTH-1:0] dat_d  [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank[p]   = (NUM_BANKS > 1) ? index[p*32 +: BW] : '0;
      addr[p]   = index[p*32 +: AW];
      in_rng[p] = index[p*32 +: 32] < 32'(SIZE);
    end
  end

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rr_d[b] = rr_q[b];
      hit     = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        sel = PW'((int'(rr_q[b]) + k) % NUM_PORTS);
        if (!hit && req_valid[sel] && bank[sel] == BW'(b)) begin
          hit      = 1'b1;
          gnt[sel] = 1'b1;
          rr_d[b]  = PW'((int'(sel) + 1) % NUM_PORTS);
        end
      end
    end
    if (!rst_n) begin
      gnt = '0;
    end
  end

  assign req_ready = gnt;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_d[p] = gnt[p] & ~req_wr[p];
      dat_d[p] = dat_q[p];
      if (rsp_d[p]) begin
        dat_d[p] = in_rng[p] ? mem[addr[p]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p] && req_wr[p] && in_rng[p]) begin
        mem[addr[p]] <= entry[p*ENTRY_WIDTH +: ENTRY_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rr_q[b] <= '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        dat_q[p] <= '0;
      end
    end else begin
      rsp_q <= rsp_d;
      rr_q  <= rr_d;
      dat_q <= dat_d;
    end
  end

`ifdef BANKED_RAM_OUTREG_EN
  logic [NUM_PORTS-1:0]   rsp2_q;
  logic [NUM_PORTS-1:0]   rsp2_d;
  logic [ENTRY_WIDTH-1:0] dat2_q [NUM_PORTS];
  logic [ENTRY_WIDTH-1:0] dat2_d [NUM_PORTS];

  always_comb begin
    rsp2_d = rsp_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dat2_d[p] = rsp_q[p] ? dat_q[p] : dat2_q[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp2_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        dat2_q[p] <= '0;
      end
    end else begin
      rsp2_q <= rsp2_d;
      dat2_q <= dat2_d;
    end
  end

  assign rsp_valid = rsp2_q;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      entry_out[p*ENTRY_WIDTH +: ENTRY_WIDTH] = dat2_q[p];
    end
  end
`else
  assign rsp_valid = rsp_q;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      entry_out[p*ENTRY_WIDTH +: ENTRY_WIDTH] = dat_q[p];
    end
  end
`endif

endmodule
